pipe_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit for the pipelined datapath, alongside the EX-stage ALU.

---
 rtl/pipe_muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_pipe_muldiv_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_muldiv_unit
// Description : Iterative radix-2 multiply/divide unit that sits beside the
//               EX-stage ALU. Executes MULTU/MULT/DIVU/DIV on WIDTH-bit
//               operands and writes a HI/LO result pair.
//               MUL: shift-add into a 2*WIDTH accumulator.
//               DIV: restoring shift-subtract.
//               Signed ops run on magnitudes with a sign fix-up at the end.
// Ports       : clk, rst (async, active-high)
//               start, op[1:0], a, b  - request, sampled only while idle
//               flush                 - synchronous abort of in-flight work
//               busy, done            - status; done is a one-cycle pulse
//               hi, lo, div_by_zero   - result, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RUN  = 2'd1;
    localparam logic [1:0]    c_FIX  = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_is_div;
    logic               r_neg_q;      // product / quotient sign
    logic               r_neg_r;      // remainder sign (follows dividend)
    logic               r_dbz_pend;
    logic               r_done;
    logic               r_dbz;
    logic [2*WIDTH-1:0] r_acc;        // {partial hi / remainder, multiplier / quotient}
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_cnt;

    // op[0] selects signed, op[1] selects divide
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_a_neg  = op[0] & a[WIDTH-1];
    assign w_b_neg  = op[0] & b[WIDTH-1];
    assign w_b_zero = (b == '0);
    assign w_abs_a  = w_a_neg ? -a : a;
    assign w_abs_b  = w_b_neg ? -b : b;

    // Multiply step: conditionally add multiplicand to the upper half, then
    // shift the whole accumulator right, catching the carry in the top bit.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and try to
    // subtract. The remainder stays below the divisor, so the shifted value
    // fits in WIDTH+1 bits and the top bit of the difference is the borrow.
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_diff;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};
    assign w_q_bit    = ~w_rem_diff[WIDTH];
    assign w_div_next = {(w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_q_bit};

    // Sign fix-up. Negating the magnitude of MIN/-1 wraps back to MIN.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (start) w_state_next = (op[1] & w_b_zero) ? c_FIX : c_RUN;
            c_RUN:  if (r_cnt == c_LAST) w_state_next = c_FIX;
            c_FIX:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
        if (flush) w_state_next = c_IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_acc      <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            if (!flush) begin
                case (r_state)
                    c_IDLE: begin
                        if (start) begin
                            r_is_div   <= op[1];
                            r_neg_q    <= w_a_neg ^ w_b_neg;
                            r_neg_r    <= w_a_neg;
                            r_dbz_pend <= op[1] & w_b_zero;
                            r_b        <= w_abs_b;
                            r_cnt      <= '0;
                            // divide-by-zero reports the raw dividend in hi
                            r_acc      <= (op[1] & w_b_zero) ? {{WIDTH{1'b0}}, a}
                                                             : {{WIDTH{1'b0}}, w_abs_a};
                        end
                    end
                    c_RUN: begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    c_FIX: begin
                        r_done <= 1'b1;
                        if (r_dbz_pend) begin
                            r_hi  <= r_acc[WIDTH-1:0];
                            r_lo  <= '1;
                            r_dbz <= 1'b1;
                        end else if (r_is_div) begin
                            r_hi  <= w_rem;
                            r_lo  <= w_quot;
                            r_dbz <= 1'b0;
                        end else begin
                            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo  <= w_prod[WIDTH-1:0];
                            r_dbz <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = (r_state != c_IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_pipe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_muldiv_unit
// Description : Self-checking bench for pipe_muldiv_unit (WIDTH=32).
//               Table of directed operations with hand-computed results,
//               followed by hand-written sequences for busy/flush/reset
//               corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    pipe_muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int c_NVEC = 14;
    vec_t vecs [c_NVEC];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Waits up to 40 edges for done; lat = edges until done (40 on timeout),
    // bcnt = post-edge samples before done that showed busy=1.
    task automatic wait_done(output int lat, output int bcnt);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
            else if (busy) bcnt++;
        end
    endtask

    // Issues one request at the next edge (called #1 after an edge).
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt);
        issue(o, x, y);
        wait_done(lat, bcnt);
    endtask

    int lat;
    int bcnt;
    int ndone;

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[2]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[3]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[4]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[5]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[6]  = '{2'd2, 32'd10,       32'd0,        32'h0000000A, 32'hFFFFFFFF, 1'b1, 1};
        vecs[7]  = '{2'd0, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 33};
        vecs[8]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        vecs[9]  = '{2'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 33};
        vecs[10] = '{2'd3, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1};
        vecs[11] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};
        vecs[12] = '{2'd2, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
        vecs[13] = '{2'd0, 32'h12345678, 32'd0,        32'd0,        32'd0,        1'b0, 33};

        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; flush = 1'b0;

        // reset state, observed before any clock edge
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- table-driven operations ----------------
        for (int i = 0; i < c_NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat - 1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_1cyc", i), {31'd0, done}, 32'd0);
        end

        // ---------------- start while busy is ignored ----------------
        issue(2'd0, 32'd5, 32'd6);                 // E0
        repeat (3) begin @(posedge clk); #1; end   // E1..E3
        issue(2'd2, 32'd99, 32'd3);                // ignored, sampled at E4
        a = 32'd1234; b = 32'd77;                  // operand changes while busy
        wait_done(lat, bcnt);
        chk("ign_lat", lat, 29);
        chk("ign_lo", lo, 32'd30);
        chk("ign_hi", hi, 32'd0);

        // ---------------- back-to-back issue in the done cycle ----------------
        run_op(2'd0, 32'd7, 32'd8, lat, bcnt);
        chk("b2b_lat", lat, 33);
        chk("b2b_lo", lo, 32'd56);

        // ---------------- flush at E10 of a DIVU ----------------
        issue(2'd2, 32'd100, 32'd7);               // E0
        repeat (9) begin @(posedge clk); #1; end   // E1..E9
        flush = 1'b1;
        @(posedge clk); #1;                        // E10
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
        chk("flush_no_done", ndone, 0);
        chk("flush_hold_lo", lo, 32'd56);
        chk("flush_hold_hi", hi, 32'd0);

        // ---------------- flush in the FIX cycle suppresses result ----------------
        issue(2'd0, 32'd2, 32'd2);
        repeat (32) begin @(posedge clk); #1; end  // E1..E32, now in FIX
        flush = 1'b1;
        @(posedge clk); #1;                        // E33
        flush = 1'b0;
        chk("fixflush_done", {31'd0, done}, 32'd0);
        chk("fixflush_busy", {31'd0, busy}, 32'd0);
        chk("fixflush_lo", lo, 32'd56);

        // ---------------- flush overrides start ----------------
        start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_vs_start_busy", {31'd0, busy}, 32'd0);

        // ---------------- async reset mid-RUN ----------------
        run_op(2'd2, 32'd1, 32'd0, lat, bcnt);     // leave dbz=1, hi=1, lo=all ones
        chk("pre_rst_dbz", {31'd0, div_by_zero}, 32'd1);
        issue(2'd0, 32'd9, 32'd9);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_op(2'd0, 32'd3, 32'd3, lat, bcnt);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_lo", lo, 32'd9);
        chk("post_rst_hi", hi, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
